// File: rtl/servo_pwm_bank.sv
// Multi-channel hobby-servo PWM generator.
// A shared frame counter sets the PWM period. A shared update tick paces the
// slew and jog modes. Each channel keeps a commanded width (pw_cur) and a
// shadow copy (pw_sh). The shadow is reloaded only on the last cycle of a
// frame, so a pulse that has already started is never cut short or stretched.
module servo_pwm_bank #(
  parameter int NCH        = 4,
  parameter int CTR_W      = 20,
  parameter int PERIOD_CYC = 1000000,
  parameter int MIN_PW     = 50000,
  parameter int MAX_PW     = 100000,
  parameter int INIT_PW    = 75000,
  parameter int STEP       = 500,
  parameter int UPDATE_CYC = 500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       enable,
  input  logic [2*NCH-1:0]     mode,
  input  logic [CTR_W*NCH-1:0] target,
  input  logic [NCH-1:0]       jog_up,
  input  logic [NCH-1:0]       jog_dn,
  output logic [NCH-1:0]       pwm_out,
  output logic [CTR_W*NCH-1:0] pw_cur,
  output logic [NCH-1:0]       at_target,
  output logic                 frame_start
);

  // Reject parameter sets that would let a width escape the frame or the counter.
  if (!(MIN_PW >= 0 && MIN_PW <= INIT_PW && INIT_PW <= MAX_PW &&
        MAX_PW < PERIOD_CYC && longint'(PERIOD_CYC) <= (longint'(1) << CTR_W) &&
        STEP >= 1 && UPDATE_CYC >= 1)) begin : g_bad_params
    $error("servo_pwm_bank: illegal parameter combination");
  end

  localparam int TICK_W = (UPDATE_CYC > 1) ? $clog2(UPDATE_CYC) : 1;

  localparam logic [CTR_W-1:0]  PER_LAST  = CTR_W'(PERIOD_CYC - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UPDATE_CYC - 1);
  localparam logic [CTR_W-1:0]  MIN_V     = CTR_W'(MIN_PW);
  localparam logic [CTR_W-1:0]  MAX_V     = CTR_W'(MAX_PW);
  localparam logic [CTR_W-1:0]  INIT_V    = CTR_W'(INIT_PW);
  localparam logic [CTR_W:0]    MIN_X     = (CTR_W+1)'(MIN_PW);
  localparam logic [CTR_W:0]    MAX_X     = (CTR_W+1)'(MAX_PW);
  // A step larger than MAX_PW behaves exactly like a step of MAX_PW, because
  // every distance inside [MIN_PW, MAX_PW] is no larger than MAX_PW. Capping
  // the step here keeps pw_cur + STEP inside CTR_W+1 bits.
  localparam int                STEP_SAT  = (STEP > MAX_PW) ? MAX_PW : STEP;
  localparam logic [CTR_W:0]    STEP_X    = (CTR_W+1)'(STEP_SAT);

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SLEW   = 2'b01;
  localparam logic [1:0] MODE_JOG    = 2'b10;

  logic              r_run;
  logic [CTR_W-1:0]  r_period_cnt;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;
  logic              w_frame_last;

  // Frame and update-tick counters. r_run holds both counters at zero until
  // the first clock after reset, so frame 0 starts on that clock.
  // NOTE: sequential state uses non-blocking (<=) assignments so that every
  // flop samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run        <= 1'b0;
      r_period_cnt <= '0;
      r_tick_cnt   <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        r_period_cnt <= (r_period_cnt == PER_LAST) ? '0 : r_period_cnt + 1'b1;
        r_tick_cnt   <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
      end
    end
  end

  assign w_tick       = r_run && (r_tick_cnt == TICK_LAST);
  assign w_frame_last = r_run && (r_period_cnt == PER_LAST);
  assign frame_start  = r_run && (r_period_cnt == '0);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CTR_W-1:0] w_tgt;
    logic [CTR_W-1:0] w_tclamp;
    logic [CTR_W-1:0] w_pw_nxt;
    logic [CTR_W-1:0] r_pw_cur;
    logic [CTR_W-1:0] r_pw_sh;
    logic             r_pwm;
    logic [1:0]       w_mode;
    logic [CTR_W:0]   w_cur_x;
    logic [CTR_W:0]   w_tc_x;
    logic [CTR_W:0]   w_diff_x;
    logic [CTR_W:0]   w_up_x;
    logic [CTR_W:0]   w_dn_x;

    assign w_tgt  = target[i*CTR_W +: CTR_W];
    assign w_mode = mode[2*i +: 2];

    // Saturate the requested width into the legal servo range.
    always_comb begin
      w_tclamp = w_tgt;
      if (w_tgt < MIN_V)      w_tclamp = MIN_V;
      else if (w_tgt > MAX_V) w_tclamp = MAX_V;
    end

    // One extra bit, so that sums cannot wrap and differences carry a sign.
    assign w_cur_x  = {1'b0, r_pw_cur};
    assign w_tc_x   = {1'b0, w_tclamp};
    assign w_diff_x = w_tc_x - w_cur_x;
    assign w_up_x   = w_cur_x + STEP_X;
    assign w_dn_x   = w_cur_x - STEP_X;

    // Next commanded width, selected by the channel mode.
    // NOTE: w_pw_nxt is given its hold value first, so every path through the
    // case assigns it and no latch is inferred.
    always_comb begin
      w_pw_nxt = r_pw_cur;
      case (w_mode)
        MODE_DIRECT: w_pw_nxt = w_tclamp;
        MODE_SLEW: begin
          if (w_tick) begin
            if (!w_diff_x[CTR_W]) begin
              w_pw_nxt = (w_diff_x <= STEP_X) ? w_tclamp : w_up_x[CTR_W-1:0];
            end else begin
              w_pw_nxt = ((w_cur_x - w_tc_x) <= STEP_X) ? w_tclamp : w_dn_x[CTR_W-1:0];
            end
          end
        end
        MODE_JOG: begin
          if (w_tick && jog_up[i] && !jog_dn[i]) begin
            w_pw_nxt = (w_up_x > MAX_X) ? MAX_V : w_up_x[CTR_W-1:0];
          end else if (w_tick && jog_dn[i] && !jog_up[i]) begin
            w_pw_nxt = (w_dn_x[CTR_W] || (w_dn_x < MIN_X)) ? MIN_V : w_dn_x[CTR_W-1:0];
          end
        end
        default: w_pw_nxt = r_pw_cur;
      endcase
    end

    // Commanded width, frame-aligned shadow copy, and the registered PWM output.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_pw_cur <= INIT_V;
        r_pw_sh  <= INIT_V;
        r_pwm    <= 1'b0;
      end else begin
        r_pw_cur <= w_pw_nxt;
        if (w_frame_last) r_pw_sh <= r_pw_cur;
        r_pwm <= r_run && enable[i] && (r_period_cnt < r_pw_sh);
      end
    end

    assign pwm_out[i]                = r_pwm;
    assign pw_cur[i*CTR_W +: CTR_W] = r_pw_cur;
    assign at_target[i]              = (r_pw_cur == w_tclamp);
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank with a small configuration: 2 channels,
// 100-cycle frame, widths 10..20, 3-cycle steps, and an update every 5 cycles.
// cyc counts clocks since reset release. After clock k, period_cnt is
// (k-1)%100 and tick_cnt is (k-1)%5. pw_cur therefore changes on slew and jog
// ticks at clocks k where k%5==1 and k>=6. The shadow width reloads at
// clocks 101, 201, ...
module tb_servo_pwm_bank;

  localparam int NCH = 2;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    enable;
  logic [2*NCH-1:0]  mode;
  logic [CW*NCH-1:0] target;
  logic [NCH-1:0]    jog_up;
  logic [NCH-1:0]    jog_dn;
  logic [NCH-1:0]    pwm_out;
  logic [CW*NCH-1:0] pw_cur;
  logic [NCH-1:0]    at_target;
  logic              frame_start;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc0 = 0, acc1 = 0, w0_last = -1, w1_last = -1;
  int fs_cnt = 0, fs_bad = 0;

  servo_pwm_bank #(
    .NCH(NCH), .CTR_W(CW), .PERIOD_CYC(100), .MIN_PW(10), .MAX_PW(20),
    .INIT_PW(15), .STEP(3), .UPDATE_CYC(5)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .target(target),
    .jog_up(jog_up), .jog_dn(jog_dn), .pwm_out(pwm_out), .pw_cur(pw_cur),
    .at_target(at_target), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // High-time per frame window. The window that follows frame start k=100m+1
  // covers clocks 100m+2 .. 100m+101, because the output lags by one cycle.
  always @(negedge clk) begin
    if (reset) begin
      acc0 = 0; acc1 = 0; fs_cnt = 0; fs_bad = 0;
    end else begin
      acc0 += int'(pwm_out[0]);
      acc1 += int'(pwm_out[1]);
      if (cyc % 100 == 1 && cyc > 1) begin
        w0_last = acc0; w1_last = acc1; acc0 = 0; acc1 = 0;
      end
      if (frame_start) begin
        fs_cnt++;
        if (cyc % 100 != 1) fs_bad++;
      end
    end
  end

  task automatic wait_to(input int k);
    int n = 0;
    while (cyc < k) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        $display("FAIL wait_to: timeout waiting for cycle %0d, at %0d", k, cyc);
        $fatal(1);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 2'b11; mode = 4'b1111;
    target = {8'd15, 8'd15}; jog_up = 2'b00; jog_dn = 2'b00;
    repeat (3) @(negedge clk);
    checks++; if (pwm_out !== 2'b00) begin errors++; $display("FAIL rst_pwm: got %b expected 00", pwm_out); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_fs: got %b expected 0", frame_start); end
    checks++; if (pw_cur !== {8'd15, 8'd15}) begin errors++; $display("FAIL rst_pw_cur: got %h expected 0f0f", pw_cur); end
    checks++; if (at_target !== 2'b11) begin errors++; $display("FAIL rst_at_target: got %b expected 11", at_target); end
    reset = 1'b0;
    wait_to(1);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL rel_fs: got %b expected 1", frame_start); end
    checks++; if (pwm_out !== 2'b00) begin errors++; $display("FAIL rel_pwm0: got %b expected 00", pwm_out); end
    wait_to(2);
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rel_fs2: got %b expected 0", frame_start); end
    checks++; if (pwm_out !== 2'b11) begin errors++; $display("FAIL rel_pwm_rise: got %b expected 11", pwm_out); end
  endtask

  task automatic test_hold_frame;
    wait_to(105);
    checks++; if (w0_last !== 15) begin errors++; $display("FAIL hold_w0: got %0d expected 15", w0_last); end
    checks++; if (w1_last !== 15) begin errors++; $display("FAIL hold_w1: got %0d expected 15", w1_last); end
    wait_to(150);
    checks++; if (fs_cnt !== 2) begin errors++; $display("FAIL hold_fs_count: got %0d expected 2", fs_cnt); end
    checks++; if (fs_bad !== 0) begin errors++; $display("FAIL hold_fs_place: got %0d misplaced expected 0", fs_bad); end
  endtask

  task automatic test_slew;
    wait_to(201);
    mode = 4'b1101; target = {8'd15, 8'd20};
    wait_to(205);
    checks++; if (pw_cur[7:0] !== 8'd15 || at_target[0] !== 1'b0) begin errors++; $display("FAIL slew_pre: got %0d/%b expected 15/0", pw_cur[7:0], at_target[0]); end
    wait_to(206);
    checks++; if (pw_cur[7:0] !== 8'd18) begin errors++; $display("FAIL slew_t1: got %0d expected 18", pw_cur[7:0]); end
    checks++; if (pw_cur[15:8] !== 8'd15) begin errors++; $display("FAIL slew_ch1_hold: got %0d expected 15", pw_cur[15:8]); end
    wait_to(210);
    checks++; if (pw_cur[7:0] !== 8'd18) begin errors++; $display("FAIL slew_between: got %0d expected 18", pw_cur[7:0]); end
    wait_to(211);
    checks++; if (pw_cur[7:0] !== 8'd20 || at_target[0] !== 1'b1) begin errors++; $display("FAIL slew_t2: got %0d/%b expected 20/1", pw_cur[7:0], at_target[0]); end
    wait_to(305);
    checks++; if (w0_last !== 15) begin errors++; $display("FAIL slew_frame_old: got %0d expected 15", w0_last); end
    wait_to(405);
    checks++; if (w0_last !== 20) begin errors++; $display("FAIL slew_frame_new: got %0d expected 20", w0_last); end
  endtask

  task automatic test_jog;
    mode = 4'b1001; jog_dn = 2'b10;
    wait_to(406);
    checks++; if (pw_cur[15:8] !== 8'd12) begin errors++; $display("FAIL jog_dn1: got %0d expected 12", pw_cur[15:8]); end
    wait_to(411);
    checks++; if (pw_cur[15:8] !== 8'd10) begin errors++; $display("FAIL jog_dn2: got %0d expected 10", pw_cur[15:8]); end
    wait_to(416);
    checks++; if (pw_cur[15:8] !== 8'd10) begin errors++; $display("FAIL jog_dn_sat: got %0d expected 10", pw_cur[15:8]); end
    jog_up = 2'b10;
    wait_to(421);
    checks++; if (pw_cur[15:8] !== 8'd10) begin errors++; $display("FAIL jog_both: got %0d expected 10", pw_cur[15:8]); end
    jog_dn = 2'b00;
    wait_to(426);
    checks++; if (pw_cur[15:8] !== 8'd13 || at_target[1] !== 1'b0) begin errors++; $display("FAIL jog_up: got %0d/%b expected 13/0", pw_cur[15:8], at_target[1]); end
    checks++; if (pw_cur[7:0] !== 8'd20) begin errors++; $display("FAIL jog_ch0_steady: got %0d expected 20", pw_cur[7:0]); end
    jog_up = 2'b00;
  endtask

  task automatic test_direct;
    mode = 4'b1100; target = {8'd15, 8'd5};
    wait_to(427);
    checks++; if (pw_cur[7:0] !== 8'd10 || at_target[0] !== 1'b1) begin errors++; $display("FAIL direct_lo: got %0d/%b expected 10/1", pw_cur[7:0], at_target[0]); end
    target = {8'd15, 8'd250};
    wait_to(428);
    checks++; if (pw_cur[7:0] !== 8'd20) begin errors++; $display("FAIL direct_hi: got %0d expected 20", pw_cur[7:0]); end
    target = {8'd15, 8'd5};
    wait_to(550);
    target = {8'd15, 8'd250};
    wait_to(605);
    checks++; if (w0_last !== 10) begin errors++; $display("FAIL direct_frame10: got %0d expected 10", w0_last); end
    checks++; if (w1_last !== 13) begin errors++; $display("FAIL direct_ch1_frame13: got %0d expected 13", w1_last); end
    wait_to(705);
    checks++; if (w0_last !== 20) begin errors++; $display("FAIL direct_frame20: got %0d expected 20", w0_last); end
  endtask

  task automatic test_enable_and_reset;
    enable = 2'b10;
    wait_to(706);
    checks++; if (pwm_out !== 2'b10) begin errors++; $display("FAIL en_off: got %b expected 10", pwm_out); end
    enable = 2'b11;
    wait_to(707);
    checks++; if (pwm_out !== 2'b11) begin errors++; $display("FAIL en_on: got %b expected 11", pwm_out); end
    wait_to(710);
    #2 reset = 1'b1;
    #1;
    checks++; if (pwm_out !== 2'b00) begin errors++; $display("FAIL midrst_pwm: got %b expected 00", pwm_out); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL midrst_fs: got %b expected 0", frame_start); end
    checks++; if (pw_cur !== {8'd15, 8'd15}) begin errors++; $display("FAIL midrst_pw_cur: got %h expected 0f0f", pw_cur); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_to(1);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL rerel_fs: got %b expected 1", frame_start); end
  endtask

  initial begin
    test_reset();
    test_hold_frame();
    test_slew();
    test_jog();
    test_direct();
    test_enable_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
